// File: rtl/pipe_pkg.sv
// Shared widths, field offsets and per-stage bundle types for the pipeline-stage registers.
package pipe_pkg;

   localparam int unsigned CTRL_W_EXE = 3;
   localparam int unsigned DATA_W_EXE = 68;

   localparam int unsigned WB_EN_BIT  = 0;
   localparam int unsigned MEM_R_BIT  = 1;
   localparam int unsigned MEM_W_BIT  = 2;

   localparam int unsigned ALU_LSB    = 0;
   localparam int unsigned ST_LSB     = 32;
   localparam int unsigned DEST_LSB   = 64;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned DEST_W     = 4;

   // Control bundle; the last member sits at bit 0 (wb_en).
   typedef struct packed {
      logic mem_w_en;
      logic mem_r_en;
      logic wb_en;
   } exe_ctrl_t;

   typedef struct packed {
      logic [DEST_W-1:0] dest;
      logic [WORD_W-1:0] st_val;
      logic [WORD_W-1:0] alu_result;
   } exe_data_t;

   typedef struct packed {
      exe_ctrl_t ctrl;
      exe_data_t data;
   } id_exe_t;

   typedef struct packed {
      exe_ctrl_t ctrl;
      exe_data_t data;
   } exe_mem_t;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
   } wb_ctrl_t;

   typedef struct packed {
      logic [DEST_W-1:0] dest;
      logic [WORD_W-1:0] mem_data;
      logic [WORD_W-1:0] alu_result;
   } wb_data_t;

   typedef struct packed {
      wb_ctrl_t ctrl;
      wb_data_t data;
   } mem_wb_t;

   // Build a flat EXE data word from its fields.
   function automatic logic [DATA_W_EXE-1:0] exe_pack(input logic [WORD_W-1:0] alu,
                                                      input logic [WORD_W-1:0] st,
                                                      input logic [DEST_W-1:0] dest);
      exe_data_t d;
      d.alu_result = alu;
      d.st_val     = st;
      d.dest       = dest;
      return DATA_W_EXE'(d);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One valid+ctrl+data entry: load a beat, or clear to a bubble (ctrl zeroed, data kept).
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = CTRL_W_EXE,
   parameter int unsigned DATA_W = DATA_W_EXE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] ld_ctrl,
   input  logic [DATA_W-1:0] ld_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
   logic [DATA_W-1:0] data_d,  data_q;

   // Clear wins over load so a flush always produces a bubble.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = ld_ctrl;
         data_d  = ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush-to-bubble and optional skid entry.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = CTRL_W_EXE,
   parameter int unsigned DATA_W = DATA_W_EXE,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   localparam bit HAS_SKID = (SKID != 0);

   logic              main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl,  skid_ctrl;
   logic [DATA_W-1:0] main_data,  skid_data;

   logic              accept, drain;
   logic              main_load, main_clear, main_from_skid;
   logic              skid_load, skid_clear;
   logic              main_valid_nx, skid_valid_nx;
   logic [CTRL_W-1:0] main_ld_ctrl;
   logic [DATA_W-1:0] main_ld_data;
   logic [1:0]        occ_d, occ_q;

   // With a skid entry in_ready depends only on a flop; without it, on out_ready too.
   generate
      if (HAS_SKID) begin : g_rdy_reg
         assign in_ready = !skid_valid;
      end else begin : g_rdy_comb
         assign in_ready = !main_valid | out_ready;
      end
   endgenerate

   // Entry transition selection; flush overrides everything.
   always_comb begin
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      accept         = in_valid & in_ready;
      drain          = main_valid & out_ready;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (skid_valid && drain) begin
         main_load      = 1'b1;
         main_from_skid = 1'b1;
         skid_clear     = 1'b1;
      end else if (accept && (!main_valid || drain)) begin
         main_load = 1'b1;
      end else if (accept && HAS_SKID) begin
         skid_load = 1'b1;
      end else if (drain) begin
         main_clear = 1'b1;
      end
   end

   always_comb begin
      main_ld_ctrl = in_ctrl;
      main_ld_data = in_data;
      if (main_from_skid) begin
         main_ld_ctrl = skid_ctrl;
         main_ld_data = skid_data;
      end
   end

   // Occupancy is tracked in its own flop, updated with the entries' next state.
   always_comb begin
      main_valid_nx = main_valid;
      skid_valid_nx = skid_valid;
      if (main_clear)     main_valid_nx = 1'b0;
      else if (main_load) main_valid_nx = 1'b1;
      if (skid_clear)     skid_valid_nx = 1'b0;
      else if (skid_load) skid_valid_nx = 1'b1;
      occ_d = 2'(main_valid_nx) + 2'(skid_valid_nx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ_q <= 2'd0;
      else     occ_q <= occ_d;
   end

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (main_load),
      .clear   (main_clear),
      .ld_ctrl (main_ld_ctrl),
      .ld_data (main_ld_data),
      .valid   (main_valid),
      .ctrl    (main_ctrl),
      .data    (main_data)
   );

   generate
      if (HAS_SKID) begin : g_skid
         pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
         ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load    (skid_load),
            .clear   (skid_clear),
            .ld_ctrl (in_ctrl),
            .ld_data (in_data),
            .valid   (skid_valid),
            .ctrl    (skid_ctrl),
            .data    (skid_data)
         );
      end else begin : g_no_skid
         assign skid_valid = 1'b0;
         assign skid_ctrl  = '0;
         assign skid_data  = '0;
      end
   endgenerate

   assign out_valid = main_valid;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus, each checked against a queue model.
module tb_pipe_stage_reg;

   localparam int unsigned CW = 3;
   localparam int unsigned DW = 68;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;

   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [CW-1:0] out_ctrl1, out_ctrl0;
   logic [DW-1:0] out_data1, out_data0;
   logic [1:0]    occ1, occ0;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   beat_t q1[$];
   beat_t q0[$];
   bit    acc1, drn1, acc0, drn0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
      .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0));

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference: a FIFO of capacity 2 (skid) or 1 (no skid); flush empties it.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q1.delete();
         q0.delete();
      end else begin
         acc1 = in_valid && (q1.size() < 2);
         drn1 = (q1.size() > 0) && out_ready;
         acc0 = in_valid && ((q0.size() == 0) || out_ready);
         drn0 = (q0.size() > 0) && out_ready;
         if (flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (drn1) void'(q1.pop_front());
            if (acc1) q1.push_back({in_ctrl, in_data});
            if (drn0) void'(q0.pop_front());
            if (acc0) q0.push_back({in_ctrl, in_data});
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("s1.out_valid", DW'(out_valid1), DW'(q1.size() > 0));
         chk("s1.occupancy", DW'(occ1), DW'(q1.size()));
         chk("s1.in_ready", DW'(in_ready1), DW'(q1.size() < 2));
         if (q1.size() > 0) begin
            chk("s1.out_ctrl", DW'(out_ctrl1), DW'(q1[0].c));
            chk("s1.out_data", out_data1, q1[0].d);
         end else begin
            chk("s1.bubble_ctrl", DW'(out_ctrl1), '0);
         end
         chk("s0.out_valid", DW'(out_valid0), DW'(q0.size() > 0));
         chk("s0.occupancy", DW'(occ0), DW'(q0.size()));
         chk("s0.in_ready", DW'(in_ready0), DW'((q0.size() == 0) || out_ready));
         if (q0.size() > 0) begin
            chk("s0.out_ctrl", DW'(out_ctrl0), DW'(q0[0].c));
            chk("s0.out_data", out_data0, q0[0].d);
         end else begin
            chk("s0.bubble_ctrl", DW'(out_ctrl0), '0);
         end
      end
   end

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic r, input logic f);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int thr;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("reset.s1.valid", DW'(out_valid1), '0);
      chk("reset.s1.occ", DW'(occ1), '0);
      chk("reset.s1.in_ready", DW'(in_ready1), DW'(1));
      chk("reset.s1.data", out_data1, '0);
      chk("reset.s0.ctrl", DW'(out_ctrl0), '0);

      // Streaming with out_ready high.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'b101, DW'((i + 1) * 'h11), 1'b1, 1'b0);
         step();
         chk("stream.s1.data", out_data1, DW'((i + 1) * 'h11));
         chk("stream.s1.ctrl", DW'(out_ctrl1), DW'(3'b101));
         chk("stream.s1.occ", DW'(occ1), DW'(1));
         chk("stream.s1.in_ready", DW'(in_ready1), DW'(1));
         chk("stream.s0.data", out_data0, DW'((i + 1) * 'h11));
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      chk("drained.s1.occ", DW'(occ1), '0);

      // Back-pressure: A in main, B in skid, C refused.
      drive(1'b1, 3'b001, DW'('hA), 1'b0, 1'b0);
      step();
      chk("bp.s1.data_a", out_data1, DW'('hA));
      drive(1'b1, 3'b001, DW'('hB), 1'b0, 1'b0);
      step();
      chk("bp.s1.occ2", DW'(occ1), DW'(2));
      chk("bp.s1.in_ready_low", DW'(in_ready1), '0);
      chk("bp.s0.hold_a", out_data0, DW'('hA));
      drive(1'b1, 3'b001, DW'('hC), 1'b0, 1'b0);
      step();
      chk("bp.s1.hold_a", out_data1, DW'('hA));
      chk("bp.s1.occ_still2", DW'(occ1), DW'(2));
      drive(1'b1, 3'b001, DW'('hC), 1'b1, 1'b0);
      step();
      chk("bp.s1.data_b", out_data1, DW'('hB));
      chk("bp.s1.occ1", DW'(occ1), DW'(1));
      chk("bp.s0.data_c", out_data0, DW'('hC));
      drive(1'b1, 3'b001, DW'('hC), 1'b1, 1'b0);
      step();
      chk("bp.s1.data_c", out_data1, DW'('hC));

      // Flush with a full stage and a beat offered in the same cycle.
      drive(1'b1, 3'b111, DW'('hE), 1'b0, 1'b0);
      step();
      chk("flush.s1.pre_occ", DW'(occ1), DW'(2));
      drive(1'b1, 3'b110, DW'('hD), 1'b1, 1'b1);
      step();
      chk("flush.s1.valid", DW'(out_valid1), '0);
      chk("flush.s1.ctrl", DW'(out_ctrl1), '0);
      chk("flush.s1.occ", DW'(occ1), '0);
      chk("flush.s0.valid", DW'(out_valid0), '0);
      chk("flush.s0.ctrl", DW'(out_ctrl0), '0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      chk("flush.s0.no_d", DW'(out_valid0), '0);

      // SKID=0: full main, draining, in_ready must be high in the same cycle.
      drive(1'b1, 3'b010, DW'('h44), 1'b0, 1'b0);
      step();
      chk("s0.full_occ", DW'(occ0), DW'(1));
      drive(1'b1, 3'b010, DW'('h55), 1'b1, 1'b0);
      #1;
      chk("s0.comb_in_ready", DW'(in_ready0), DW'(1));
      step();
      chk("s0.swap_occ", DW'(occ0), DW'(1));
      chk("s0.swap_data", out_data0, DW'('h55));

      // Asynchronous reset with two held beats.
      drive(1'b1, 3'b011, DW'('h66), 1'b0, 1'b0);
      step();
      chk("arst.s1.pre_occ", DW'(occ1), DW'(2));
      #2 rst = 1'b1;
      #1;
      chk("arst.s1.valid", DW'(out_valid1), '0);
      chk("arst.s1.ctrl", DW'(out_ctrl1), '0);
      chk("arst.s1.data", out_data1, '0);
      chk("arst.s1.occ", DW'(occ1), '0);
      chk("arst.s1.in_ready", DW'(in_ready1), DW'(1));
      drive(1'b1, 3'b100, DW'('h77), 1'b1, 1'b0);
      step();
      chk("arst.s1.ignored", DW'(out_valid1), '0);
      rst = 1'b0;
      step();
      chk("arst.s1.first_accept", out_data1, DW'('h77));
      chk("arst.s1.first_ctrl", DW'(out_ctrl1), DW'(3'b100));

      // Random traffic with varying back-pressure.
      thr = 6;
      for (int n = 0; n < 10000; n++) begin
         if (n % 500 == 0) thr = int'($urandom_range(1, 10));
         drive(1'($urandom_range(0, 9) < 7), 3'($urandom),
               {4'($urandom), 32'($urandom), 32'($urandom)},
               1'($urandom_range(0, 9) < thr), 1'($urandom_range(0, 49) == 0));
         step();
      end

      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (4) step();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
